paralelo_serial_tx: RTL and testbench
=====================================

Name: paralelo_serial_tx

Overview:
Parallel-to-serial transmitter for the byte-serial link. It accepts 8-bit words on a byte-slot handshake and shifts them out MSB-first, one bit per clk_32f cycle. It fills idle slots with the COMMA character. After reset it sends a fixed comma preamble so the far-end receiver can align before any data is sent.

Parameters:
SYNC_COMMAS, 4, number of comma bytes sent after reset before the first data slot; legal range 1..255
COMMA, 8'hBC, idle/alignment character

Ports:
clk_32f  input  1  bit clock; all logic on its rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  8  parallel byte to send
valid_in  input  1  data_in holds a byte to send
data_out  output  1  serial bit stream, MSB first
ready_out  output  1  high in the cycle whose closing edge samples data_in/valid_in
active_out  output  1  high once the comma preamble is complete (link in data phase)
comma_collision_out  output  1  one-cycle pulse: a valid byte equal to COMMA was accepted

Behaviour:
- Clock/reset: one clock, clk_32f; reset is asynchronous and active-low. Asserting reset at any time forces reset values immediately; deasserting it restarts the full preamble.
- State: 8-bit shift register sr, 3-bit bit counter bit_cnt, 8-bit comma counter comma_cnt, 2-state FSM {SYNC, ACTIVE}.
- Reset values: sr=COMMA, bit_cnt=0, comma_cnt=0, FSM=SYNC, active_out=0, comma_collision_out=0.
- Serial output: data_out = sr[7], a direct register output. It is therefore 1 during reset with COMMA=8'hBC.
- Edge numbering: edge 1 is the first rising edge after reset deassertion.
- Shifting, bit_cnt!=7: sr <= {sr[6:0],1'b0}; bit_cnt += 1.
- Byte boundary, bit_cnt==7: bit_cnt <= 0 (wraps 7->0). sr loads the next byte:
  - data_in if ready_out && valid_in;
  - COMMA otherwise.
- Byte timing: each byte occupies exactly 8 cycles on data_out. Byte n (n>=0) drives its MSB from edge 8n until edge 8n+1.
- ready_out = (bit_cnt==7) && (FSM==ACTIVE || comma_cnt==SYNC_COMMAS-1). It decodes registers only and never depends on inputs.
- Handshake:
  - data_in/valid_in are sampled only at the edge closing a ready_out cycle; values at other edges are ignored.
  - No backpressure on the upstream side: a byte not presented in its slot is replaced by COMMA.
  - Latency: MSB appears on data_out the cycle after the sampling edge. LSB appears 7 cycles later.
- SYNC state:
  - Each byte boundary increments comma_cnt.
  - When comma_cnt reaches SYNC_COMMAS-1 at a boundary, FSM -> ACTIVE and active_out <= 1 at that same edge.
  - Exactly SYNC_COMMAS commas are sent. The first data slot is byte index SYNC_COMMAS; its sampling edge is 8*SYNC_COMMAS.
- ACTIVE: remains there until reset. comma_cnt holds its value.
- Collision: if a byte is accepted with data_in==COMMA, it is sent unchanged and comma_collision_out pulses for exactly one cycle, set at the sampling edge. It is cleared at the next edge unless another collision occurs.
- valid_in high during SYNC or outside ready_out cycles: no effect, no error indication.

Optional Feature:
TX_BYTE_COUNT_EN
- Defined: adds output byte_count_out [15:0], reset 0. It increments at every edge that accepts a valid byte and wraps 16'hFFFF -> 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, valid_in=0 for 64 cycles -> data_out repeats 1,0,1,1,1,1,0,0 per byte. active_out rises at edge 24 (SYNC_COMMAS=4); ready_out is high only in the cycles before edges 32, 40, 48, 56, 64.
- valid_in=1 with data_in=8'hA5 held from edge 25 -> 8'hA5 is sampled at edge 32 and serialized 1,0,1,0,0,1,0,1 after edges 32..39. Subsequent slots repeat A5 while valid_in stays high.
- Back-to-back bytes 8'h00, 8'hFF, 8'h3C in consecutive slots, then valid_in=0 -> the stream shows the three bytes contiguously, followed by 8'hBC. There are no gap bits.
- valid_in=1 with data_in=8'hBC in a slot -> the byte is sent as BC and comma_collision_out is high for exactly one cycle after the sampling edge.
- Reset asserted asynchronously mid-byte in ACTIVE (between edges) -> outputs take reset values immediately (data_out=1, active_out=0). After release, a full 4-comma preamble precedes the next ready_out.
- With TX_BYTE_COUNT_EN: 3 accepted bytes -> byte_count_out=3. Preload scenario reaching 65536 accepted bytes -> wraps to 0.

Source files
------------

// File: rtl/paralelo_serial_tx_if.sv
// rtl/paralelo_serial_tx_if.sv - byte-slot handshake and serial-link signals of paralelo_serial_tx
// Optional macro TX_BYTE_COUNT_EN adds byte_count_out.
interface paralelo_serial_tx_if;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        data_out;
    logic        ready_out;
    logic        active_out;
    logic        comma_collision_out;
`ifdef TX_BYTE_COUNT_EN
    logic [15:0] byte_count_out;
`endif

    modport master (
        output data_in, valid_in,
`ifdef TX_BYTE_COUNT_EN
        input  byte_count_out,
`endif
        input  data_out, ready_out, active_out, comma_collision_out
    );

    modport slave (
        input  data_in, valid_in,
`ifdef TX_BYTE_COUNT_EN
        output byte_count_out,
`endif
        output data_out, ready_out, active_out, comma_collision_out
    );
endinterface

// File: rtl/paralelo_serial_tx.sv
// rtl/paralelo_serial_tx.sv - MSB-first parallel-to-serial transmitter with comma preamble and idle fill
// Optional macro TX_BYTE_COUNT_EN adds a 16-bit accepted-byte counter.
module paralelo_serial_tx #(
    parameter int         SYNC_COMMAS = 4,
    parameter logic [7:0] COMMA       = 8'hBC
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    paralelo_serial_tx_if.slave  bus
);
    typedef enum logic {SYNC, ACTIVE} state_t;

    localparam logic [7:0] LAST_COMMA = 8'(SYNC_COMMAS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_sr;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_comma_cnt;
    logic        r_collision;
    logic        w_boundary;
    logic        w_ready;
    logic        w_accept;
    logic        w_last_sync;

    assign w_boundary  = (r_bit_cnt == 3'd7);
    assign w_ready     = w_boundary && ((r_state == ACTIVE) || (r_comma_cnt == LAST_COMMA));
    assign w_accept    = w_ready && bus.valid_in;
    // Leaving SYNC at the boundary where the count lands on the last preamble comma;
    // the second term covers a single-comma preamble, where the count already sits there.
    assign w_last_sync = ((r_comma_cnt + 8'd1) == LAST_COMMA) || (r_comma_cnt == LAST_COMMA);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SYNC:    if (w_boundary && w_last_sync) w_state_next = ACTIVE;
            ACTIVE:  w_state_next = ACTIVE;
            default: w_state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_sr        <= COMMA;
            r_bit_cnt   <= 3'd0;
            r_comma_cnt <= 8'd0;
            r_collision <= 1'b0;
        end else begin
            r_bit_cnt   <= r_bit_cnt + 3'd1;
            r_collision <= w_accept && (bus.data_in == COMMA);
            if (w_boundary) begin
                r_sr <= w_accept ? bus.data_in : COMMA;
                if (r_state == SYNC) begin
                    r_comma_cnt <= r_comma_cnt + 8'd1;
                end
            end else begin
                r_sr <= {r_sr[6:0], 1'b0};
            end
        end
    end

`ifdef TX_BYTE_COUNT_EN
    logic [15:0] r_byte_count;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_byte_count <= 16'd0;
        end else if (w_accept) begin
            r_byte_count <= r_byte_count + 16'd1;
        end
    end

    assign bus.byte_count_out = r_byte_count;
`endif

    assign bus.data_out            = r_sr[7];
    assign bus.ready_out           = w_ready;
    assign bus.active_out          = (r_state == ACTIVE);
    assign bus.comma_collision_out = r_collision;
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb/tb_paralelo_serial_tx.sv - self-checking bench for paralelo_serial_tx
// Optional macro TX_BYTE_COUNT_EN enables byte-count checks.
module tb_paralelo_serial_tx;
    localparam int         SYNC  = 4;
    localparam logic [7:0] COMMA = 8'hBC;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    paralelo_serial_tx_if bus ();

    paralelo_serial_tx #(.SYNC_COMMAS(SYNC), .COMMA(COMMA)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_32f = ~clk_32f;

    // Reference: edges since reset, byte currently on the wire, pending collision, accepted count.
    int         m_e;
    logic [7:0] m_byte;
    logic       m_coll;
    logic [15:0] m_cnt;

    always @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            m_e    <= 0;
            m_byte <= COMMA;
            m_coll <= 1'b0;
            m_cnt  <= 16'd0;
        end else begin
            m_e    <= m_e + 1;
            m_coll <= 1'b0;
            if ((m_e + 1) % 8 == 0) begin
                if (((m_e + 1) / 8 >= SYNC) && bus.valid_in) begin
                    m_byte <= bus.data_in;
                    m_coll <= (bus.data_in == COMMA);
                    m_cnt  <= m_cnt + 16'd1;
                end else begin
                    m_byte <= COMMA;
                end
            end
        end
    end

    function automatic logic exp_ready(int e);
        return (e % 8 == 7) && ((e + 1) / 8 >= SYNC);
    endfunction

    always @(negedge clk_32f) begin
        if (reset) begin
            logic x_do, x_rdy, x_act;
            x_do  = m_byte[7 - (m_e % 8)];
            x_rdy = exp_ready(m_e);
            x_act = (m_e >= 8 * (SYNC - 1));
            n_vec++;
            if (bus.data_out !== x_do || bus.ready_out !== x_rdy ||
                bus.active_out !== x_act || bus.comma_collision_out !== m_coll) begin
                n_err++;
                $display("FAIL cycle e=%0d: got do/rdy/act/coll=%b%b%b%b required %b%b%b%b",
                         m_e, bus.data_out, bus.ready_out, bus.active_out,
                         bus.comma_collision_out, x_do, x_rdy, x_act, m_coll);
            end
`ifdef TX_BYTE_COUNT_EN
            n_vec++;
            if (bus.byte_count_out !== m_cnt) begin
                n_err++;
                $display("FAIL byte_count e=%0d: got %0d required %0d", m_e, bus.byte_count_out, m_cnt);
            end
`endif
        end
    end

    task automatic check1(string name, logic [15:0] got, logic [15:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic wait_slot();
        int k;
        for (k = 0; k < 80; k++) begin
            @(negedge clk_32f);
            if (reset && exp_ready(m_e)) break;
        end
        if (k == 80) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_slot: got timeout required ready slot");
        end
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [7:0] exp_byte;
        logic       exp_coll;
    } slot_vec_t;

    slot_vec_t tbl [9];

    initial begin
        logic [7:0] cap;
        logic       coll0;
        int         k;

        tbl[0] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
        tbl[1] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
        tbl[2] = '{1'b1, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 8'hFF, 8'hFF, 1'b0};
        tbl[4] = '{1'b1, 8'h3C, 8'h3C, 1'b0};
        tbl[5] = '{1'b0, 8'h55, COMMA, 1'b0};
        tbl[6] = '{1'b1, COMMA, COMMA, 1'b1};
        tbl[7] = '{1'b0, COMMA, COMMA, 1'b0};
        tbl[8] = '{1'b1, 8'h81, 8'h81, 1'b0};

        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        #22;
        check1("reset data_out", 16'(bus.data_out), 16'd1);
        check1("reset active_out", 16'(bus.active_out), 16'd0);
        check1("reset ready_out", 16'(bus.ready_out), 16'd0);
        check1("reset collision", 16'(bus.comma_collision_out), 16'd0);
        @(negedge clk_32f);
        reset = 1'b1;

        // Idle preamble and comma fill; the per-cycle checker covers every bit.
        repeat (64) @(negedge clk_32f);

        // Slot table: inputs held only in their slot, eight captured bits compared.
        wait_slot();
        for (int i = 0; i < 9; i++) begin
            bus.valid_in = tbl[i].valid;
            bus.data_in  = tbl[i].data;
            coll0 = 1'b0;
            for (int b = 0; b < 8; b++) begin
                @(negedge clk_32f);
                cap[7 - b] = bus.data_out;
                if (b == 0) coll0 = bus.comma_collision_out;
                if (b == 1) check1($sformatf("coll clear slot %0d", i), 16'(bus.comma_collision_out), 16'd0);
            end
            check1($sformatf("slot %0d byte", i), 16'(cap), 16'(tbl[i].exp_byte));
            check1($sformatf("slot %0d coll", i), 16'(coll0), 16'(tbl[i].exp_coll));
        end
        bus.valid_in = 1'b0;

        // Random inputs changed every cycle; only slot-edge values should matter.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_32f);
            bus.valid_in = 1'($urandom_range(0, 1));
            bus.data_in  = ($urandom_range(0, 5) == 0) ? COMMA : 8'($urandom);
        end
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h5A;

        // Asynchronous reset mid-byte in the data phase.
        @(posedge clk_32f);
        @(posedge clk_32f);
        #3 reset = 1'b0;
        #1;
        check1("async reset data_out", 16'(bus.data_out), 16'd1);
        check1("async reset active_out", 16'(bus.active_out), 16'd0);
        check1("async reset ready_out", 16'(bus.ready_out), 16'd0);
        @(negedge clk_32f);
        reset = 1'b1;
        for (k = 1; k <= 100; k++) begin
            @(negedge clk_32f);
            if (bus.ready_out) break;
        end
        check1("preamble after reset", 16'(k), 16'(8 * SYNC - 1));
        bus.valid_in = 1'b0;
        repeat (16) @(negedge clk_32f);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
